alu_cmd_sequencer: RTL and testbench



---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_cmd_sequencer_if.sv | 47 ++++
 rtl/alu_cmd_fifo.sv | 54 +++++
 rtl/alu_cmd_sequencer.sv | 127 ++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode map, flag bit positions and default widths.
package alu_pkg;

  localparam int ALU_DATA_WIDTH   = 8;
  localparam int ALU_OPCODE_WIDTH = 4;
  localparam int ALU_FLAGS_WIDTH  = 4;

  typedef enum logic [3:0] {
    OP_NEG = 4'd0,
    OP_NOT = 4'd1,
    OP_INC = 4'd2,
    OP_DEC = 4'd3,
    OP_ADD = 4'd4,
    OP_SUB = 4'd5,
    OP_ADC = 4'd6,
    OP_SBC = 4'd7,
    OP_AND = 4'd8,
    OP_OR  = 4'd9,
    OP_XOR = 4'd10,
    OP_SHL = 4'd11,
    OP_SHR = 4'd12,
    OP_ROL = 4'd13,
    OP_ROR = 4'd14,
    OP_EQ  = 4'd15
  } alu_op_e;

  // Bit positions inside the 4-bit {V,C,Z,P} flag vector.
  typedef enum int unsigned {
    FLAG_P = 0,
    FLAG_Z = 1,
    FLAG_C = 2,
    FLAG_V = 3
  } alu_flag_e;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU and result-slot signals of the ALU command sequencer.
interface alu_cmd_sequencer_if #(
  parameter int DATA_WIDTH   = alu_pkg::ALU_DATA_WIDTH,
  parameter int OPCODE_WIDTH = alu_pkg::ALU_OPCODE_WIDTH,
  parameter int CNT_WIDTH    = 16
);

  logic                    in_valid;
  logic                    in_ready;
  logic [OPCODE_WIDTH-1:0] in_opcode;
  logic [DATA_WIDTH-1:0]   in_a;
  logic [DATA_WIDTH-1:0]   in_b;
  logic                    in_chain;

  logic [DATA_WIDTH-1:0]   alu_a;
  logic [DATA_WIDTH-1:0]   alu_b;
  logic [OPCODE_WIDTH-1:0] alu_opcode;
  logic [DATA_WIDTH-1:0]   alu_result;
  logic [3:0]              alu_flags;

  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_WIDTH-1:0]   out_result;
  logic [3:0]              out_flags;
  logic [CNT_WIDTH-1:0]    done_cnt;

  // Environment side: issues commands, hosts the ALU, consumes results.
  modport master (
    output in_valid, in_opcode, in_a, in_b, in_chain,
    input  in_ready,
    input  alu_a, alu_b, alu_opcode,
    output alu_result, alu_flags,
    input  out_valid, out_result, out_flags, done_cnt,
    output out_ready
  );

  // Sequencer side.
  modport slave (
    input  in_valid, in_opcode, in_a, in_b, in_chain,
    output in_ready,
    output alu_a, alu_b, alu_opcode,
    input  alu_result, alu_flags,
    output out_valid, out_result, out_flags, done_cnt,
    input  out_ready
  );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; head is the oldest entry, valid when not empty.
module alu_cmd_fifo #(
  parameter int WIDTH = 21,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage array: data only, never reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issue stage for the external combinational ALU: queues commands, drives
// the ALU from the queue head and captures result/flags into an output slot.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH   = ALU_DATA_WIDTH,
  parameter int OPCODE_WIDTH = ALU_OPCODE_WIDTH,
  parameter int FIFO_DEPTH   = 4,
  parameter int CNT_WIDTH    = 16
) (
  input logic                clk,
  input logic                rst_n,
  alu_cmd_sequencer_if.slave bus
);

  localparam int ENTRY_W = 1 + OPCODE_WIDTH + 2 * DATA_WIDTH;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  logic [ENTRY_W-1:0]         push_data;
  logic [ENTRY_W-1:0]         head;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       head_chain;
  logic [OPCODE_WIDTH-1:0]    head_opcode;
  logic [DATA_WIDTH-1:0]      head_a;
  logic [DATA_WIDTH-1:0]      head_b;

  logic                       push;
  logic                       issue;
  logic                       consume;

  slot_state_e                slot_state;
  logic                       vld_p1;
  logic [DATA_WIDTH-1:0]      result_p1;
  logic [ALU_FLAGS_WIDTH-1:0] flags_p1;
  logic [DATA_WIDTH-1:0]      last_result;
  logic [CNT_WIDTH-1:0]       done_cnt_q;

  assign push_data = {bus.in_chain, bus.in_opcode, bus.in_a, bus.in_b};
  assign {head_chain, head_opcode, head_a, head_b} = head;

  // in_ready depends only on occupancy, so a same-cycle pop never frees a slot.
  assign push    = bus.in_valid & ~fifo_full;
  assign issue   = ~fifo_empty & (~vld_p1 | bus.out_ready);
  assign consume = vld_p1 & bus.out_ready;

  alu_cmd_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (issue),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head)
  );

  // ALU operands come straight from the head; forced to zero when nothing is queued.
  always_comb begin
    bus.alu_a      = '0;
    bus.alu_b      = '0;
    bus.alu_opcode = '0;
    if (!fifo_empty) begin
      bus.alu_opcode = head_opcode;
      bus.alu_b      = head_b;
      bus.alu_a      = head_chain ? last_result : head_a;
    end
  end

  // ---- stage p1: output slot, captured on issue, held under backpressure ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_state  <= SLOT_EMPTY;
      vld_p1      <= 1'b0;
      result_p1   <= '0;
      flags_p1    <= '0;
      last_result <= '0;
    end else begin
      if (issue) begin
        result_p1   <= bus.alu_result;
        flags_p1    <= bus.alu_flags;
        last_result <= bus.alu_result;
      end
      case (slot_state)
        SLOT_EMPTY: begin
          if (issue) begin
            slot_state <= SLOT_FULL;
            vld_p1     <= 1'b1;
          end
        end
        SLOT_FULL: begin
          if (bus.out_ready && !issue) begin
            slot_state <= SLOT_EMPTY;
            vld_p1     <= 1'b0;
          end
        end
        default: begin
          slot_state <= SLOT_EMPTY;
          vld_p1     <= 1'b0;
        end
      endcase
    end
  end

  // Count of results taken by the consumer; wraps freely.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done_cnt_q <= '0;
    end else if (consume) begin
      done_cnt_q <= done_cnt_q + 1'b1;
    end
  end

  assign bus.in_ready   = ~fifo_full;
  assign bus.out_valid  = vld_p1;
  assign bus.out_result = result_p1;
  assign bus.out_flags  = flags_p1;
  assign bus.done_cnt   = done_cnt_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: hosts a behavioural ALU, keeps a queue-based
// reference of the sequencer, and runs directed tables plus random traffic.
module tb_alu_cmd_sequencer;
  import alu_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = 4;

  logic clk = 1'b0;
  logic rst_n;

  alu_cmd_sequencer_if #(.DATA_WIDTH(8), .OPCODE_WIDTH(4), .CNT_WIDTH(CW)) bus ();

  alu_cmd_sequencer #(
    .DATA_WIDTH   (8),
    .OPCODE_WIDTH (4),
    .FIFO_DEPTH   (DEPTH),
    .CNT_WIDTH    (CW)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: returns {V,C,Z,P,result}. P = strictly positive result.
  function automatic logic [11:0] alu_fn(input logic [3:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    logic [8:0] w;
    logic [7:0] r;
    logic       c, v;
    c = 1'b0;
    v = 1'b0;
    w = '0;
    case (op)
      OP_NEG: begin r = 8'(0 - a); v = (a == 8'h80); end
      OP_NOT: r = ~a;
      OP_ADD: begin
        w = {1'b0, a} + {1'b0, b};
        r = w[7:0];
        c = w[8];
        v = (a[7] == b[7]) && (r[7] != a[7]);
      end
      OP_SUB: begin
        w = {1'b0, a} - {1'b0, b};
        r = w[7:0];
        c = w[8];
        v = (a[7] != b[7]) && (r[7] != a[7]);
      end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      default: r = a + b + 8'(op);
    endcase
    return {v, c, (r == 8'h00), (r != 8'h00) && !r[7], r};
  endfunction

  always_comb begin
    {bus.alu_flags, bus.alu_result} = alu_fn(bus.alu_opcode, bus.alu_a, bus.alu_b);
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       chain;
  } cmd_t;

  cmd_t       q[$];
  bit         m_vld;
  logic [7:0] m_res;
  logic [3:0] m_flags;
  logic [7:0] m_last;
  int         m_done;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_check();
    logic [7:0] ea, eb;
    logic [3:0] eop;
    ea = 0; eb = 0; eop = 0;
    if (q.size() != 0) begin
      eop = q[0].op;
      eb  = q[0].b;
      ea  = q[0].chain ? m_last : q[0].a;
    end
    check("in_ready",   32'(bus.in_ready),   32'(q.size() != DEPTH));
    check("out_valid",  32'(bus.out_valid),  32'(m_vld));
    check("out_result", 32'(bus.out_result), 32'(m_res));
    check("out_flags",  32'(bus.out_flags),  32'(m_flags));
    check("done_cnt",   32'(bus.done_cnt),   32'(m_done));
    check("alu_a",      32'(bus.alu_a),      32'(ea));
    check("alu_b",      32'(bus.alu_b),      32'(eb));
    check("alu_opcode", 32'(bus.alu_opcode), 32'(eop));
  endtask

  task automatic model_update(input bit iv, input logic [3:0] op, input logic [7:0] a,
                              input logic [7:0] b, input bit ch, input bit rdy,
                              input bit rstn);
    bit         iss, cons, psh;
    cmd_t       h, n;
    logic [11:0] fr;
    if (!rstn) begin
      q.delete();
      m_vld = 0; m_res = 0; m_flags = 0; m_last = 0; m_done = 0;
    end else begin
      iss  = (q.size() != 0) && (!m_vld || rdy);
      cons = m_vld && rdy;
      psh  = iv && (q.size() != DEPTH);
      if (cons) m_done = (m_done + 1) % (1 << CW);
      if (iss) begin
        h = q.pop_front();
        fr = alu_fn(h.op, h.chain ? m_last : h.a, h.b);
        m_res = fr[7:0]; m_flags = fr[11:8]; m_last = fr[7:0]; m_vld = 1;
      end else if (cons) begin
        m_vld = 0;
      end
      if (psh) begin
        n.op = op; n.a = a; n.b = b; n.chain = ch;
        q.push_back(n);
      end
    end
  endtask

  // One clock: drive at negedge+1, check state, edge, update model, return at negedge+1.
  task automatic step(input bit iv, input logic [3:0] op, input logic [7:0] a,
                      input logic [7:0] b, input bit ch, input bit rdy, input bit rstn);
    bus.in_valid  = iv;
    bus.in_opcode = op;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_chain  = ch;
    bus.out_ready = rdy;
    rst_n         = rstn;
    model_check();
    @(posedge clk);
    model_update(iv, op, a, b, ch, rdy, rstn);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic idle(input bit rdy);
    step(0, 0, 0, 0, 0, rdy, 1);
  endtask

  typedef struct {
    bit         iv;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    bit         ch;
    bit         rdy;
    bit         e_vld;
    logic [7:0] e_res;
    logic [3:0] e_flags;
    int         e_done;
    logic [7:0] e_alu_a;
  } vec_t;

  vec_t vecs[4];

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 0;
    bus.in_opcode = 0;
    bus.in_a      = 0;
    bus.in_b      = 0;
    bus.in_chain  = 0;
    bus.out_ready = 0;
    m_vld = 0; m_res = 0; m_flags = 0; m_last = 0; m_done = 0;

    // Directed add + chained AND; expectations are post-edge values.
    vecs[0] = '{1, OP_ADD, 8'h7F, 8'h01, 0, 1, 0, 8'h00, 4'h0, 0, 8'h7F};
    vecs[1] = '{1, OP_AND, 8'hFF, 8'h00, 1, 1, 1, 8'h80, 4'b1000, 0, 8'h80};
    vecs[2] = '{0, 4'h0,   8'h00, 8'h00, 0, 1, 1, 8'h00, 4'b0010, 1, 8'h00};
    vecs[3] = '{0, 4'h0,   8'h00, 8'h00, 0, 1, 0, 8'h00, 4'b0010, 2, 8'h00};

    @(negedge clk);
    #1;
    do_reset();
    do_reset();
    check("reset_in_ready",  32'(bus.in_ready),  32'd1);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_done_cnt",  32'(bus.done_cnt),  32'd0);

    for (int i = 0; i < 4; i++) begin
      step(vecs[i].iv, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ch, vecs[i].rdy, 1);
      check($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'(vecs[i].e_vld));
      if (vecs[i].e_vld) begin
        check($sformatf("vec%0d_result", i), 32'(bus.out_result), 32'(vecs[i].e_res));
        check($sformatf("vec%0d_flags", i),  32'(bus.out_flags),  32'(vecs[i].e_flags));
      end
      check($sformatf("vec%0d_done", i),  32'(bus.done_cnt), 32'(vecs[i].e_done));
      check($sformatf("vec%0d_alu_a", i), 32'(bus.alu_a),    32'(vecs[i].e_alu_a));
    end

    // Backpressure: 6 pushes with out_ready=0, only 5 accepted.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i == 5) check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
      step(1, OP_ADD, 8'(i * 16 + 1), 8'(i), 0, 0, 1);
    end
    check("bp_hold_valid",  32'(bus.out_valid),  32'd1);
    check("bp_hold_result", 32'(bus.out_result), 32'h01);
    for (int i = 0; i < 6; i++) idle(1);
    check("bp_drained_valid", 32'(bus.out_valid), 32'd0);
    check("bp_drained_done",  32'(bus.done_cnt),  32'd5);

    // Streaming at occupancy 2: push and pop every cycle.
    do_reset();
    for (int i = 0; i < 3; i++) step(1, OP_SUB, 8'(8'h40 + i), 8'(i), 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      step(1, 4'($urandom_range(15)), 8'($urandom), 8'($urandom), 1'($urandom_range(1)), 1, 1);
      check("stream_in_ready", 32'(bus.in_ready), 32'd1);
    end
    for (int i = 0; i < 4; i++) idle(1);
    check("stream_done", 32'(bus.done_cnt), 32'(11 % 16));

    // Reset mid-operation, then a chained command must see A=0.
    do_reset();
    for (int i = 0; i < 4; i++) step(1, OP_XOR, 8'(8'h11 * (i + 1)), 8'h0F, 0, 0, 1);
    check("mid_out_valid_before", 32'(bus.out_valid), 32'd1);
    do_reset();
    check("mid_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_in_ready",  32'(bus.in_ready),  32'd1);
    check("mid_done",      32'(bus.done_cnt),  32'd0);
    step(1, OP_ADD, 8'hEE, 8'h05, 1, 1, 1);
    check("mid_chain_alu_a", 32'(bus.alu_a), 32'h00);
    idle(0);
    check("mid_chain_result", 32'(bus.out_result), 32'h05);
    check("mid_chain_flags",  32'(bus.out_flags),  32'b0001);
    idle(1);

    // Counter wrap: 17 consumed results on a 4-bit counter.
    do_reset();
    for (int i = 0; i < 17; i++) step(1, OP_OR, 8'(i), 8'h80, 0, 1, 1);
    idle(1);
    idle(1);
    check("wrap_done", 32'(bus.done_cnt), 32'd1);

    // Random traffic against the reference model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(99) < 70), 4'($urandom_range(15)), 8'($urandom), 8'($urandom),
           ($urandom_range(99) < 30), ($urandom_range(99) < 60), ($urandom_range(199) != 0));
    end
    idle(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
